mix64_inv: RTL and testbench

MIX64_INV -- requirements
Module: mix64_inv

---
 rtl/mix64_inv_if.sv | 19 +
 rtl/mix64_inv.sv | 105 ++++++++++
 tb/tb_mix64_inv.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mix64_inv_if.sv
// Handshake bundle for the mix64_inv decoder: input word stream and decoded output stream.
interface mix64_inv_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mix64_inv.sv
// Iterative inverse of the 8-round 64-bit xor/add/mul/rotate mixer.
// One inverse round per clock, rounds 8 down to 1, fixed 8-cycle latency.
module mix64_inv (
    input  logic       clk,
    input  logic       rst,
    mix64_inv_if.slave bus,
    output logic       busy
);
    // Newton iteration for the 2-adic inverse of an odd constant; m is its own inverse mod 8.
    function automatic logic [63:0] inv64(input logic [63:0] m);
        logic [63:0] y;
        y = m;
        for (int i = 0; i < 5; i++) begin
            y = y * (64'd2 - m * y);
        end
        return y;
    endfunction

    localparam logic [63:0] XC [8] = '{
        64'h9445827458d1e38f, 64'h2fc55b45c61ebe31, 64'h31a9687a17608c12, 64'hc6ef667a38bdce09,
        64'hb6d5b0156ab6173c, 64'hf7717a58c7bb2d9e, 64'h0f665597571bc48d, 64'h473f56b61d111668
    };
    localparam logic [63:0] AC [8] = '{
        64'hf053cfc591ae5a85, 64'h4e317ba1cc4318f6, 64'hed0c25e75b89aced, 64'h71122c73403c6eb9,
        64'hc1dc47474a382c47, 64'hfc8209b7ca52282a, 64'h85334c2b17e4655a, 64'h60fd0697f9c18b48
    };
    localparam logic [63:0] MC [8] = '{
        64'hf61475c34efa5845, 64'h0248ce601f038a07, 64'h975bf348d59b263b, 64'hcccb0c9343f99e2b,
        64'h684a6a759995e6bd, 64'h2613486a2bb075b9, 64'h91e7d7118a7c3b1f, 64'he741548ac2acdc99
    };
    localparam logic [63:0] MI [8] = '{
        inv64(MC[0]), inv64(MC[1]), inv64(MC[2]), inv64(MC[3]),
        inv64(MC[4]), inv64(MC[5]), inv64(MC[6]), inv64(MC[7])
    };
    localparam logic [5:0] RC [8] = '{6'd46, 6'd15, 6'd41, 6'd29, 6'd4, 6'd44, 6'd1, 6'd44};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [63:0] t_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;

    logic [6:0]  rot;
    logic [63:0] t_rot;
    logic [63:0] t_next;

    // Counter value c selects round c+1; every rotate amount is nonzero so the split shift is safe.
    always_comb begin
        rot    = {1'b0, RC[cnt_q]};
        t_rot  = (t_q << rot) | (t_q >> (7'd64 - rot));
        t_next = ((t_rot * MI[cnt_q]) - AC[cnt_q]) ^ XC[cnt_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            t_q         <= 64'h0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_ready_q && bus.in_valid) begin
                        t_q        <= bus.in_data;
                        cnt_q      <= 3'd7;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    t_q   <= t_next;
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = t_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mix64_inv.sv
// Scoreboard bench for mix64_inv: golden forward mixer feeds encoded words, monitor checks decodes.
module tb_mix64_inv;
    localparam logic [63:0] XC [8] = '{
        64'h9445827458d1e38f, 64'h2fc55b45c61ebe31, 64'h31a9687a17608c12, 64'hc6ef667a38bdce09,
        64'hb6d5b0156ab6173c, 64'hf7717a58c7bb2d9e, 64'h0f665597571bc48d, 64'h473f56b61d111668
    };
    localparam logic [63:0] AC [8] = '{
        64'hf053cfc591ae5a85, 64'h4e317ba1cc4318f6, 64'hed0c25e75b89aced, 64'h71122c73403c6eb9,
        64'hc1dc47474a382c47, 64'hfc8209b7ca52282a, 64'h85334c2b17e4655a, 64'h60fd0697f9c18b48
    };
    localparam logic [63:0] MC [8] = '{
        64'hf61475c34efa5845, 64'h0248ce601f038a07, 64'h975bf348d59b263b, 64'hcccb0c9343f99e2b,
        64'h684a6a759995e6bd, 64'h2613486a2bb075b9, 64'h91e7d7118a7c3b1f, 64'he741548ac2acdc99
    };
    localparam int RC [8] = '{46, 15, 41, 29, 4, 44, 1, 44};

    logic clk;
    logic rst;
    logic busy;
    mix64_inv_if bus ();

    mix64_inv dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int unsigned checks;
    int unsigned failures;
    int          cyc;
    logic [63:0] exp_q [$];
    int          acc_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] fwd(input logic [63:0] x);
        logic [63:0] t;
        t = x;
        for (int i = 0; i < 8; i++) begin
            t = t ^ XC[i];
            t = t + AC[i];
            t = t * MC[i];
            t = (t >> RC[i]) | (t << (64 - RC[i]));
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives an encoded word and waits (bounded) for acceptance; returns the accept edge.
    task automatic send(input logic [63:0] x, input bit drop, output int acc);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = fwd(x);
        n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        acc = -1;
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
        end else begin
            acc = cyc + 1;
            exp_q.push_back(x);
            acc_q.push_back(acc);
            tick();
            if (drop) bus.in_valid = 1'b0;
        end
    endtask

    // Monitor: latency on out_valid rise, data on handshake, one-cycle pulse after handshake.
    initial begin
        bit          prev_ov;
        bit          pulse_chk;
        logic [63:0] e;
        int          a;
        prev_ov   = 1'b0;
        pulse_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (pulse_chk) begin
                chk("out_valid_pulse", 64'(bus.out_valid), 64'd0);
                pulse_chk = 1'b0;
            end
            if (!rst && bus.out_valid && !prev_ov) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    a = acc_q.pop_front();
                    chk("latency", 64'(cyc - a), 64'd8);
                end
            end
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", bus.out_data, 64'hx);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e);
                end
                pulse_chk = 1'b1;
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        int          a1;
        int          a2;
        int          n;
        logic [63:0] hold;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'h0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_data", bus.out_data, 64'h0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();
        chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

        // Zero word with consumer always ready.
        send(64'h0, 1'b1, a1);
        chk("busy_in_run", 64'(busy), 64'd1);
        chk("in_ready_in_run", 64'(bus.in_ready), 64'd0);
        repeat (12) tick();

        // Back-to-back words with in_valid held high.
        send(64'hFFFFFFFFFFFFFFFF, 1'b0, a1);
        send(64'h0123456789ABCDEF, 1'b1, a2);
        chk("b2b_accept_gap", 64'(a2 - a1), 64'd10);
        repeat (12) tick();

        // Stall in DONE for 5 cycles with a stray in_valid.
        bus.out_ready = 1'b0;
        send(64'h5A5A_0F0F_1234_8765, 1'b1, a1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("stall_reached_done", 64'(bus.out_valid), 64'd1);
        hold = bus.out_data;
        chk("stall_data_value", hold, 64'h5A5A_0F0F_1234_8765);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom};
            tick();
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_out_data", bus.out_data, hold);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("idle_after_handoff", 64'(bus.in_ready), 64'd1);
        chk("busy_after_handoff", 64'(busy), 64'd0);
        repeat (2) tick();

        // Reset mid-computation: pending word is dropped.
        send(64'h1111_2222_3333_4444, 1'b1, a1);
        repeat (3) tick();
        exp_q.delete();
        acc_q.delete();
        rst = 1'b1;
        tick();
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_out_data", bus.out_data, 64'h0);
        chk("abort_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (12) tick();
        send(64'hDEADBEEFCAFEBABE, 1'b1, a1);
        repeat (12) tick();

        // Random words with random idle gaps.
        for (int i = 0; i < 200; i++) begin
            send({$urandom, $urandom}, 1'($urandom_range(0, 1)), a1);
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
